oka71_seq_ctrl: RTL and testbench

OKA71_SEQ_CTRL -- requirements
Module: oka71_seq_ctrl

---
 rtl/oka71_seq_ctrl.sv | 103 ++++++++++
 tb/tb_oka71_seq_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oka71_seq_ctrl.sv
// oka71_seq_ctrl: 71-bit carry-less multiplier built from one time-shared 36-bit Karatsuba core over even/odd splits.
module oka71_kar36 (
  input  logic [35:0] x,
  input  logic [35:0] z,
  output logic [70:0] p
);
  function automatic logic [34:0] clm18(input logic [17:0] u, input logic [17:0] v);
    clm18 = '0;
    for (int i = 0; i < 18; i++) if (v[i]) clm18 ^= 35'(u) << i;
  endfunction
  logic [34:0] lo, hi, mid;
  always_comb begin
    lo  = clm18(x[17:0], z[17:0]);
    hi  = clm18(x[35:18], z[35:18]);
    mid = clm18(x[17:0] ^ x[35:18], z[17:0] ^ z[35:18]) ^ lo ^ hi;
    // lo and hi occupy disjoint bit ranges, so only the middle term needs xor-merging
    p   = {hi, 1'b0, lo} ^ (71'(mid) << 18);
  end
endmodule

module oka71_seq_ctrl #(
  parameter int N = 71
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-2:0] y,
  output logic           busy,
  output logic [15:0]    op_count
);
  typedef enum logic [2:0] {IDLE, MUL0, MUL1, MUL2, COMB, DONE} state_t;
  state_t state, nxt;
  logic [N-1:0] ra, rb, p0, p1, p2, pm, p1s;
  logic [35:0] ea, oa, eb, ob, mx, mz;
  logic [2*N-2:0] yc;
  oka71_kar36 u_kar (.x(mx), .z(mz), .p(pm));
  always_comb begin
    ea = '0;
    oa = '0;
    eb = '0;
    ob = '0;
    for (int i = 0; i < 36; i++) begin
      ea[i] = ra[2*i];
      eb[i] = rb[2*i];
    end
    for (int i = 0; i < 35; i++) begin
      oa[i] = ra[2*i+1];
      ob[i] = rb[2*i+1];
    end
    mx = state == MUL0 ? ea : state == MUL1 ? oa : ea ^ oa;
    mz = state == MUL0 ? eb : state == MUL1 ? ob : eb ^ ob;
  end
  // recombine: even bits get E*E plus x^2-shifted O*O, odd bits get the Karatsuba middle term
  always_comb begin
    yc  = '0;
    p1s = {p1[N-2:0], 1'b0};
    for (int i = 0; i < N; i++) yc[2*i] = p0[i] ^ p1s[i];
    for (int i = 0; i < N-1; i++) yc[2*i+1] = p0[i] ^ p1[i] ^ p2[i];
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = in_valid ? MUL0 : IDLE;
      MUL0:    nxt = MUL1;
      MUL1:    nxt = MUL2;
      MUL2:    nxt = COMB;
      COMB:    nxt = DONE;
      DONE:    nxt = out_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ra       <= '0;
      rb       <= '0;
      p0       <= '0;
      p1       <= '0;
      p2       <= '0;
      y        <= '0;
      op_count <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        ra <= a;
        rb <= b;
      end
      if (state == MUL0) p0 <= pm;
      if (state == MUL1) p1 <= pm;
      if (state == MUL2) p2 <= pm;
      if (state == COMB) y <= yc;
      if (state == DONE && out_ready) op_count <= op_count + 16'd1;
    end
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
endmodule

// File: tb/tb_oka71_seq_ctrl.sv
// tb_oka71_seq_ctrl: randomized check of oka71_seq_ctrl against a bit-serial carry-less multiply model.
module tb_oka71_seq_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [70:0] a = '0, b = '0;
  logic in_ready, out_valid, busy;
  logic [140:0] y;
  logic [15:0] op_count;
  logic [15:0] exp_cnt = '0;
  int total = 0, bad = 0;

  oka71_seq_ctrl #(.N(71)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  function automatic logic [140:0] clmul(input logic [70:0] x, input logic [70:0] z);
    clmul = '0;
    for (int i = 0; i < 71; i++) if (z[i]) clmul ^= 141'(x) << i;
  endfunction

  function automatic logic [70:0] rnd71();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[70:0];
  endfunction

  task automatic run_op(input logic [70:0] x, input logic [70:0] z, output logic [140:0] got, output int lat);
    a = x;
    b = z;
    in_valid = 1'b1;
    out_ready = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 20);
    got = y;
    @(posedge clk);
    #1;
    exp_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({in_ready, out_valid, busy} !== 3'b100 || y !== '0 || op_count !== 16'd0) begin
      bad++;
      $display("FAIL reset: rdy/vld/busy=%b y=%h cnt=%0d required 100/0/0", {in_ready, out_valid, busy}, y, op_count);
    end
  endtask

  task automatic test_basic();
    logic [140:0] got;
    logic [140:0] top;
    int lat;
    a = 71'd1;
    b = 71'd1;
    in_valid = 1'b1;
    rst_n = 1'b1;
    exp_cnt = '0;
    run_op(71'd1, 71'd1, got, lat);
    total++;
    if (lat !== 5 || got !== 141'd1) begin
      bad++;
      $display("FAIL one_x_one: lat=%0d y=%h required lat=5 y=1", lat, got);
    end
    total++;
    if (op_count !== 16'd1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL one_x_one_cnt: cnt=%0d vld=%b required 1/0", op_count, out_valid);
    end
    run_op(71'd3, 71'd3, got, lat);
    total++;
    if (got !== 141'd5) begin
      bad++;
      $display("FAIL three_sq: y=%h required 5", got);
    end
    run_op(71'd1 << 70, 71'd1 << 70, got, lat);
    top = 141'd1 << 140;
    total++;
    if (got !== top) begin
      bad++;
      $display("FAIL top_bit: y=%h required %h", got, top);
    end
    run_op({71{1'b1}}, {71{1'b1}}, got, lat);
    total++;
    if (got !== clmul({71{1'b1}}, {71{1'b1}})) begin
      bad++;
      $display("FAIL all_ones: y=%h required %h", got, clmul({71{1'b1}}, {71{1'b1}}));
    end
  endtask

  task automatic test_random();
    logic [140:0] got;
    logic [70:0] x, z;
    int lat;
    for (int k = 0; k < 1500; k++) begin
      x = rnd71();
      z = rnd71();
      if (k % 7 == 0) x = x & (71'd1 << $urandom_range(70));
      run_op(x, z, got, lat);
      total++;
      if (got !== clmul(x, z) || lat !== 5) begin
        bad++;
        $display("FAIL random[%0d]: y=%h lat=%0d required y=%h lat=5", k, got, lat, clmul(x, z));
      end
    end
    total++;
    if (op_count !== exp_cnt) begin
      bad++;
      $display("FAIL random_cnt: cnt=%0d required %0d", op_count, exp_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [70:0] x, z;
    logic [140:0] ex;
    int n;
    x = rnd71();
    z = rnd71();
    ex = clmul(x, z);
    a = x;
    b = z;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    a = rnd71();
    b = rnd71();
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || y !== ex) begin
        bad++;
        $display("FAIL hold[%0d]: vld=%b rdy=%b busy=%b y=%h required 1/0/1 y=%h", k, out_valid, in_ready, busy, y, ex);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_cnt++;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || y !== ex || op_count !== exp_cnt) begin
      bad++;
      $display("FAIL release: vld=%b busy=%b rdy=%b y=%h cnt=%0d required 0/0/1 y=%h cnt=%0d",
               out_valid, busy, in_ready, y, op_count, ex, exp_cnt);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_mid_reset();
    logic [140:0] got;
    logic [70:0] x, z;
    int lat;
    int seen;
    a = rnd71();
    b = rnd71();
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, busy} !== 3'b100 || y !== '0 || op_count !== 16'd0) begin
      bad++;
      $display("FAIL mid_reset: rdy/vld/busy=%b y=%h cnt=%0d required 100/0/0", {in_ready, out_valid, busy}, y, op_count);
    end
    exp_cnt = '0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL discard: out_valid seen %0d times required 0", seen);
    end
    x = rnd71();
    z = rnd71();
    run_op(x, z, got, lat);
    total++;
    if (got !== clmul(x, z) || op_count !== 16'd1) begin
      bad++;
      $display("FAIL after_reset: y=%h cnt=%0d required y=%h cnt=1", got, op_count, clmul(x, z));
    end
  endtask

  task automatic test_back_to_back();
    logic [140:0] q[$];
    logic [140:0] ex;
    logic [70:0] x, z;
    logic acc;
    int cyc = 0, last = -1, n;
    in_valid = 1'b1;
    out_ready = 1'b1;
    repeat (1210) begin
      x = rnd71();
      z = rnd71();
      a = x;
      b = z;
      acc = in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        if (last >= 0) begin
          total++;
          if (cyc - last !== 6) begin
            bad++;
            $display("FAIL interval: %0d cycles required 6", cyc - last);
          end
        end
        last = cyc;
        q.push_back(clmul(x, z));
      end
      if (out_valid) begin
        exp_cnt++;
        ex = q.size() > 0 ? q.pop_front() : '0;
        total++;
        if (y !== ex) begin
          bad++;
          $display("FAIL b2b: y=%h required %h", y, ex);
        end
      end
    end
    in_valid = 1'b0;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) begin
        exp_cnt++;
        ex = q.pop_front();
        total++;
        if (y !== ex) begin
          bad++;
          $display("FAIL b2b_drain: y=%h required %h", y, ex);
        end
      end
    end
    @(posedge clk);
    #1;
    total++;
    if (q.size() !== 0 || op_count !== exp_cnt || busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end: pending=%0d cnt=%0d busy=%b required 0/%0d/0", q.size(), op_count, busy, exp_cnt);
    end
  endtask

  initial begin
    #12;
    test_reset();
    test_basic();
    test_random();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
